// File: rtl/seg7_scan.sv
// Four-digit multiplexed 7-segment scanner with blank guard slots between digits
// and frame-synchronous, tear-free update of the displayed value.
module seg7_scan #(
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned GUARD    = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic        i_load,
    input  logic [15:0] iv_value,
    input  logic [3:0]  iv_blank,
    output logic [6:0]  ov_seg,
    output logic [3:0]  ov_an,
    output logic        o_frame
);

    localparam logic [15:0] PreLoad   = 16'(PRESCALE - 1);
    localparam logic [15:0] GuardLoad = 16'(GUARD - 1);

    typedef enum logic [1:0] {StIdle, StOn, StGuard} state_e;

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] pend_q, pend_d;
    logic        pend_v_q, pend_v_d;
    logic [15:0] shadow_q, shadow_d;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  an_q, an_d;
    logic        frame_q, frame_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        shadow_d = shadow_q;
        frame_d  = 1'b0;

        if (i_load) begin
            pend_d   = iv_value;
            pend_v_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                idx_d = 2'd0;
                cnt_d = 16'd0;
                if (i_load) shadow_d = iv_value;
                if (i_enable) begin
                    state_d = StOn;
                    cnt_d   = PreLoad;
                end
            end
            StOn: begin
                if (!i_enable) begin
                    state_d = StIdle;
                    idx_d   = 2'd0;
                    cnt_d   = 16'd0;
                end else if (cnt_q == 16'd0) begin
                    state_d = StGuard;
                    cnt_d   = GuardLoad;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StGuard: begin
                if (!i_enable) begin
                    state_d = StIdle;
                    idx_d   = 2'd0;
                    cnt_d   = 16'd0;
                end else if (cnt_q == 16'd0) begin
                    state_d = StOn;
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = PreLoad;
                    // Frame boundary: the only point where the shown value may change
                    if (idx_q == 2'd3) begin
                        frame_d = 1'b1;
                        if (i_load) begin
                            shadow_d = iv_value;
                        end else if (pend_v_q) begin
                            shadow_d = pend_q;
                        end
                        pend_v_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = 2'd0;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // Outputs are registered from next-state so they track the FSM without extra lag
    always_comb begin
        seg_d = 7'h00;
        an_d  = 4'hF;
        if (state_d == StOn) begin
            an_d = ~(4'b0001 << idx_d);
            if (!iv_blank[idx_d]) seg_d = seg_decode(shadow_d[{idx_d, 2'b00} +: 4]);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= StIdle;
            idx_q    <= 2'd0;
            cnt_q    <= 16'd0;
            pend_q   <= 16'd0;
            pend_v_q <= 1'b0;
            shadow_q <= 16'd0;
            seg_q    <= 7'h00;
            an_q     <= 4'hF;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            shadow_q <= shadow_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            frame_q  <= frame_d;
        end
    end

    assign ov_seg  = seg_q;
    assign ov_an   = an_q;
    assign o_frame = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: a frame-position model predicts every output cycle,
// and a monitor compares the DUT against the queued predictions.
module tb_seg7_scan;

    localparam int P         = 4;
    localparam int G         = 1;
    localparam int SLOT      = P + G;
    localparam int FRAME_LEN = 4 * SLOT;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_enable = 1'b0;
    logic        i_load = 1'b0;
    logic [15:0] iv_value = 16'h0;
    logic [3:0]  iv_blank = 4'h0;
    logic [6:0]  ov_seg;
    logic [3:0]  ov_an;
    logic        o_frame;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: position within the frame rather than FSM state
    logic        m_run = 1'b0;
    int          m_t = 0;
    logic [15:0] m_shadow = 16'h0;
    logic [15:0] m_pend = 16'h0;
    logic        m_pv = 1'b0;

    logic [11:0] exp_q [$];

    seg7_scan #(.PRESCALE(P), .GUARD(G)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_enable (i_enable),
        .i_load   (i_load),
        .iv_value (iv_value),
        .iv_blank (iv_blank),
        .ov_seg   (ov_seg),
        .ov_an    (ov_an),
        .o_frame  (o_frame)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got seg/an/frame %h/%h/%b, want %h/%h/%b", name, $time,
                     got[11:5], got[4:1], got[0], want[11:5], want[4:1], want[0]);
        end
    endtask

    task automatic model_step(input logic en, input logic ld, input logic [15:0] val,
                              input logic [3:0] blk);
        logic       fr;
        logic [6:0] seg;
        logic [3:0] an;
        int         d;
        fr  = 1'b0;
        seg = 7'h00;
        an  = 4'hF;
        if (!m_run) begin
            if (ld) begin
                m_shadow = val;
                m_pend   = val;
                m_pv     = 1'b1;
            end
            if (en) begin
                m_run = 1'b1;
                m_t   = 0;
            end
        end else if (!en) begin
            m_run = 1'b0;
            if (ld) begin
                m_pend = val;
                m_pv   = 1'b1;
            end
        end else begin
            m_t++;
            if (ld) begin
                m_pend = val;
                m_pv   = 1'b1;
            end
            if (m_t == FRAME_LEN) begin
                m_t = 0;
                fr  = 1'b1;
                if (ld) m_shadow = val;
                else if (m_pv) m_shadow = m_pend;
                m_pv = 1'b0;
            end
        end
        if (m_run && (m_t % SLOT) < P) begin
            d  = m_t / SLOT;
            an = ~(4'b0001 << d);
            if (!blk[d]) seg = seg_tbl[m_shadow[4*d +: 4]];
        end
        exp_q.push_back({seg, an, fr});
    endtask

    task automatic cycle(input logic en, input logic ld, input logic [15:0] val,
                         input logic [3:0] blk);
        @(negedge i_clk);
        i_enable = en;
        i_load   = ld;
        iv_value = val;
        iv_blank = blk;
        model_step(en, ld, val, blk);
    endtask

    task automatic run(input int n, input logic [3:0] blk);
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 16'h0, blk);
    endtask

    task automatic run_to(input int t);
        for (int k = 0; k < 2 * FRAME_LEN && !(m_run && m_t == t); k++)
            cycle(1'b1, 1'b0, 16'h0, 4'h0);
    endtask

    task automatic model_reset();
        m_run    = 1'b0;
        m_t      = 0;
        m_shadow = 16'h0;
        m_pend   = 16'h0;
        m_pv     = 1'b0;
        exp_q.delete();
    endtask

    // Async reset between edges: outputs must blank before the next clock edge
    task automatic async_reset();
        @(posedge i_clk);
        #3;
        i_rst    = 1'b1;
        i_enable = 1'b0;
        i_load   = 1'b0;
        iv_value = 16'h0;
        iv_blank = 4'h0;
        #1;
        check("async_reset_blank", {ov_seg, ov_an, o_frame}, {7'h00, 4'hF, 1'b0});
        model_reset();
        @(negedge i_clk);
        check("reset_held", {ov_seg, ov_an, o_frame}, {7'h00, 4'hF, 1'b0});
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    always @(posedge i_clk) begin
        #1;
        if (!i_rst && exp_q.size() != 0) begin
            logic [11:0] e;
            e = exp_q.pop_front();
            check("cycle_output", {ov_seg, ov_an, o_frame}, e);
        end
    end

    initial begin
        model_reset();
        @(negedge i_clk);
        @(negedge i_clk);
        check("reset_state", {ov_seg, ov_an, o_frame}, {7'h00, 4'hF, 1'b0});
        i_rst = 1'b0;

        // Load in idle, then scan continuously for a few frames
        cycle(1'b0, 1'b1, 16'h3210, 4'h0);
        cycle(1'b0, 1'b0, 16'h0, 4'h0);
        run(3 * FRAME_LEN + 5, 4'h0);

        // Load mid-frame during digit 2: takes effect only at the next frame
        run_to(2 * SLOT);
        cycle(1'b1, 1'b1, 16'hFEDC, 4'h0);
        run(2 * FRAME_LEN, 4'h0);

        // Live blanking of digit 2
        run(FRAME_LEN + 3, 4'b0100);

        // Drop enable during digit 1, then restart from digit 0
        run_to(SLOT + 1);
        cycle(1'b0, 1'b0, 16'h0, 4'h0);
        cycle(1'b0, 1'b1, 16'h5A5A, 4'h0);
        cycle(1'b0, 1'b0, 16'h0, 4'h0);
        run(2 * FRAME_LEN, 4'h0);

        // Pending load discarded by an async reset mid-ON
        run_to(FRAME_LEN - 1);
        run(2, 4'h0);
        cycle(1'b1, 1'b1, 16'h9876, 4'h0);
        cycle(1'b1, 1'b0, 16'h0, 4'h0);
        async_reset();
        run(FRAME_LEN + 4, 4'h0);

        // Randomised traffic
        for (int k = 0; k < 800; k++) begin
            logic        en;
            logic        ld;
            logic [15:0] val;
            logic [3:0]  blk;
            en  = ($urandom % 16) != 0;
            ld  = ($urandom % 10) == 0;
            val = 16'($urandom);
            blk = (($urandom % 4) == 0) ? 4'($urandom) : 4'h0;
            cycle(en, ld, val, blk);
        end
        cycle(1'b0, 1'b0, 16'h0, 4'h0);

        @(posedge i_clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
